// File: rtl/pulse_conditioner.sv
// Pulse conditioner: synchronizes and debounces a raw tachometer/ignition pulse,
// applies a holdoff between accepted rises, and flags a stall when pulses stop.
module pulse_conditioner #(
  parameter int unsigned FILT      = 4,
  parameter int unsigned HOLDOFF   = 1000,
  parameter int unsigned STALL_CYC = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pulse_in,
  output logic       pulse_out,
  output logic       level_out,
  output logic       stall,
  output logic [7:0] reject_cnt
);

  typedef enum logic [1:0] {LOW, RISE_Q, HIGH, FALL_Q} state_t;

  localparam logic [7:0]  QC_LAST = 8'(FILT - 1);
  localparam logic [15:0] HC_LOAD = 16'(HOLDOFF);
  localparam logic [23:0] SC_MAX  = 24'(STALL_CYC);

  logic        r_s1, r_s2;
  state_t      r_state;
  logic [7:0]  r_qc;
  logic [15:0] r_hc;
  logic [23:0] r_sc;
  logic        r_pulse_out, r_level_out, r_stall;
  logic [7:0]  r_reject_cnt;

  state_t      w_state_nxt;
  logic [7:0]  w_qc_nxt;
  logic        w_enter_high, w_hc_clear, w_accept, w_reject;
  logic [23:0] w_sc_inc;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_qc_nxt    = r_qc;
    case (r_state)
      LOW: if (r_s2) begin
        if (FILT == 1) w_state_nxt = HIGH;
        else begin
          w_state_nxt = RISE_Q;
          w_qc_nxt    = 8'd1;
        end
      end
      RISE_Q: begin
        if (!r_s2) begin
          w_state_nxt = LOW;
          w_qc_nxt    = 8'd0;
        end else if (r_qc == QC_LAST) begin
          w_state_nxt = HIGH;
          w_qc_nxt    = 8'd0;
        end else begin
          w_qc_nxt    = r_qc + 8'd1;
        end
      end
      HIGH: if (!r_s2) begin
        if (FILT == 1) w_state_nxt = LOW;
        else begin
          w_state_nxt = FALL_Q;
          w_qc_nxt    = 8'd1;
        end
      end
      FALL_Q: begin
        if (r_s2) begin
          w_state_nxt = HIGH;
          w_qc_nxt    = 8'd0;
        end else if (r_qc == QC_LAST) begin
          w_state_nxt = LOW;
          w_qc_nxt    = 8'd0;
        end else begin
          w_qc_nxt    = r_qc + 8'd1;
        end
      end
      default: begin
        w_state_nxt = LOW;
        w_qc_nxt    = 8'd0;
      end
    endcase
  end

  // Only a qualified rise counts; FALL_Q bouncing back to HIGH is not a new pulse.
  assign w_enter_high = (w_state_nxt == HIGH) && ((r_state == LOW) || (r_state == RISE_Q));
  // hc reaches zero on this very edge when it is 1, so HOLDOFF-spaced rises pass.
  assign w_hc_clear   = (r_hc <= 16'd1);
  assign w_accept     = w_enter_high && w_hc_clear;
  assign w_reject     = w_enter_high && !w_hc_clear;
  assign w_sc_inc     = (r_sc == SC_MAX) ? r_sc : r_sc + 24'd1;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    // NOTE: synchronous reset has priority and clears every register, including mid-count state.
    if (reset) begin
      r_s1         <= 1'b0;
      r_s2         <= 1'b0;
      r_state      <= LOW;
      r_qc         <= 8'd0;
      r_hc         <= 16'd0;
      r_sc         <= 24'd0;
      r_pulse_out  <= 1'b0;
      r_level_out  <= 1'b0;
      r_stall      <= 1'b1;
      r_reject_cnt <= 8'd0;
    end else begin
      r_s1        <= pulse_in;
      r_s2        <= r_s1;
      r_state     <= w_state_nxt;
      r_qc        <= w_qc_nxt;
      r_pulse_out <= w_accept;
      r_level_out <= (w_state_nxt == HIGH) || (w_state_nxt == FALL_Q);

      if (w_accept)          r_hc <= HC_LOAD;
      else if (r_hc != 16'd0) r_hc <= r_hc - 16'd1;

      if (w_accept) r_sc <= 24'd0;
      else          r_sc <= w_sc_inc;

      if (w_accept)                r_stall <= 1'b0;
      else if (w_sc_inc == SC_MAX) r_stall <= 1'b1;

      if (w_reject && (r_reject_cnt != 8'hFF)) r_reject_cnt <= r_reject_cnt + 8'd1;
    end
  end

  assign pulse_out  = r_pulse_out;
  assign level_out  = r_level_out;
  assign stall      = r_stall;
  assign reject_cnt = r_reject_cnt;

endmodule

// File: doc/pulse_conditioner.md
PULSE_CONDITIONER -- requirements
Module: pulse_conditioner

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- FILT, 4, consecutive equal synchronized samples (1..255) needed to change the filtered level.
- HOLDOFF, 1000, minimum clock cycles between accepted pulses (1..65535).
- STALL_CYC, 1000000, pulse-free cycles before stall asserts (1..2^24-1).

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state changes on its rising edge.
- reset, in, 1, synchronous, active-high.
- pulse_in, in, 1, raw asynchronous tachometer/ignition pulse.
- pulse_out, out, 1, one-cycle strobe per accepted rising pulse; feeds the RPM measurement stage.
- level_out, out, 1, debounced pulse level.
- stall, out, 1, no accepted pulse for STALL_CYC cycles.
- reject_cnt, out, 8, count of rises rejected by holdoff.

Function
REQ-003 pulse_in SHALL pass through a two-flop synchronizer (s1, s2) before any other use.
REQ-004 The filter FSM SHALL have four states: LOW, RISE_Q, HIGH, FALL_Q. It SHALL use an 8-bit qualification counter qc.
REQ-005 LOW transitions:
- s2=1 with FILT=1 -> HIGH.
- s2=1 otherwise -> RISE_Q with qc=1.
REQ-006 RISE_Q transitions:
- s2=0 -> LOW with qc=0.
- s2=1 and qc=FILT-1 -> HIGH.
- otherwise qc increments.
REQ-007 HIGH and FALL_Q SHALL mirror REQ-005/006 with the polarity inverted, returning to LOW after FILT consecutive s2=0 samples.
REQ-008 level_out SHALL be registered: 1 in HIGH and FALL_Q, 0 in LOW and RISE_Q.
REQ-009 Latency: if pulse_in is first sampled high at edge k and then held, level_out SHALL rise at edge k+1+FILT. Falling latency SHALL be identical.
REQ-010 Pulses or gaps shorter than FILT s2 samples SHALL produce no change on level_out, pulse_out or reject_cnt.
REQ-011 A 16-bit holdoff counter hc SHALL behave as follows:
- load HOLDOFF on the edge pulse_out asserts;
- otherwise decrement while nonzero.
REQ-012 At the edge where the FSM enters HIGH:
- if hc=0, pulse_out SHALL be 1 for exactly one cycle;
- if hc!=0, pulse_out SHALL stay 0 and reject_cnt SHALL increment, saturating at 255.
REQ-013 Pulse spacing: pulses exactly HOLDOFF cycles apart SHALL both be accepted; spacing HOLDOFF-1 SHALL reject the second. Rejected rises SHALL NOT reload hc.
REQ-014 Stall counter sc is 24 bits:
- cleared on the edge pulse_out asserts;
- otherwise increments, saturating at STALL_CYC.
REQ-015 stall SHALL be registered:
- asserts on the edge sc reaches STALL_CYC;
- clears on the same edge pulse_out asserts.
REQ-016 pulse_out SHALL never be asserted on two consecutive cycles.

Reset
REQ-017 reset=1 at an edge SHALL set all of the following to their reset values, taking priority over all other events:
- s1=s2=0, FSM=LOW, qc=0, hc=0, sc=0;
- pulse_out=0, level_out=0, reject_cnt=0, stall=1.
REQ-018 Reset asserted mid-qualification or mid-holdoff SHALL discard that state.
REQ-019 If pulse_in is high when reset deasserts, it SHALL be qualified as a new rise with the REQ-009 latency and accepted (hc=0).

Verification
REQ-020 FILT=4, HOLDOFF=1000: reset released, pulse_in 0->1 sampled at edge k -> level_out=1 and pulse_out=1 for one cycle at edge k+5, stall 1->0 at k+5.
REQ-021 Glitch of 3 cycles high on pulse_in from LOW -> level_out, pulse_out and reject_cnt unchanged; a 4-cycle high pulse -> one pulse_out.
REQ-022 Clean rises with accepted-pulse spacing of 1000 cycles then 999 cycles:
- first and second pulses accepted;
- third rise: level_out=1, pulse_out=0, reject_cnt=1.
REQ-023 300 rises each 10 cycles apart after one accepted pulse, HOLDOFF=65535 -> reject_cnt saturates at 255 and holds.
REQ-024 STALL_CYC=100: no rises after an accepted pulse at edge t -> stall=1 at edge t+100; next accepted pulse clears stall in the same cycle pulse_out=1.
REQ-025 Reset asserted during RISE_Q with qc=2 and hc=500 -> next cycle all outputs at reset values. With pulse_in held high, pulse_out is accepted at release edge +5.
